// File: rtl/ft245_tx_writer.sv
// FT245 write-side sequencer: pops one byte from the transmit FIFO and drives
// the data / WR strobe / hold / recovery cycle on the FT245 pins.
module ft245_tx_writer #(
  parameter int data_width     = 8,
  parameter int setup_cycles   = 1,
  parameter int pulse_cycles   = 2,
  parameter int hold_cycles    = 1,
  parameter int recover_cycles = 3,
  parameter int count_width    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [data_width-1:0]  fifo_rd_data,
  input  logic                   ft_txe_n,
  output logic                   ft_wr,
  output logic [data_width-1:0]  ft_data,
  output logic                   ft_data_oe,
  output logic                   busy,
  output logic [count_width-1:0] byte_count
);

  localparam int max_ab  = (setup_cycles > pulse_cycles) ? setup_cycles : pulse_cycles;
  localparam int max_cd  = (hold_cycles > recover_cycles) ? hold_cycles : recover_cycles;
  localparam int max_cyc = (max_ab > max_cd) ? max_ab : max_cd;
  localparam int cnt_w   = (max_cyc > 1) ? $clog2(max_cyc) : 1;

  localparam logic [cnt_w-1:0] setup_load   = cnt_w'(setup_cycles - 1);
  localparam logic [cnt_w-1:0] pulse_load   = cnt_w'(pulse_cycles - 1);
  localparam logic [cnt_w-1:0] hold_load    = cnt_w'(hold_cycles - 1);
  localparam logic [cnt_w-1:0] recover_load = cnt_w'(recover_cycles - 1);

  // IDLE wait | POP rd_en | LATCH capture | SETUP data | STROBE wr | HOLD data | RECOVER bus off
  typedef enum logic [2:0] {
    IDLE, POP, LATCH, SETUP, STROBE, HOLD, RECOVER
  } state_t;

  state_t           state;
  logic [cnt_w-1:0] cnt;
  logic             txe_meta_n;
  logic             txe_sync_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      txe_meta_n <= 1'b1;
      txe_sync_n <= 1'b1;
      fifo_rd_en <= 1'b0;
      ft_wr      <= 1'b0;
      ft_data    <= '0;
      ft_data_oe <= 1'b0;
      busy       <= 1'b0;
      byte_count <= '0;
    end else begin
      txe_meta_n <= ft_txe_n;
      txe_sync_n <= txe_meta_n;
      fifo_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty && !txe_sync_n) begin
            state      <= POP;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        POP: state <= LATCH;
        LATCH: begin
          ft_data    <= fifo_rd_data;
          ft_data_oe <= 1'b1;
          cnt        <= setup_load;
          state      <= SETUP;
        end
        SETUP: begin
          if (cnt == '0) begin
            ft_wr <= 1'b1;
            cnt   <= pulse_load;
            state <= STROBE;
          end else begin
            cnt <= cnt - cnt_w'(1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            ft_wr      <= 1'b0;
            byte_count <= byte_count + count_width'(1);
            cnt        <= hold_load;
            state      <= HOLD;
          end else begin
            cnt <= cnt - cnt_w'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            ft_data_oe <= 1'b0;
            cnt        <= recover_load;
            state      <= RECOVER;
          end else begin
            cnt <= cnt - cnt_w'(1);
          end
        end
        RECOVER: begin
          // TXE# deliberately not looked at; the synchroniser refills meanwhile
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - cnt_w'(1);
          end
        end
        default: begin
          state      <= IDLE;
          ft_wr      <= 1'b0;
          ft_data_oe <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ft245_tx_writer.md
Name: ft245_tx_writer

Overview:
- Downstream consumer of the transmit dual-clock FIFO, running in the FT245 clock domain.
- Pops one byte at a time through the FIFO read port and drives the FT245 parallel write strobe sequence: data, WR pulse, hold, recovery.
- Gates every pop on the chip's TXE# status and on FIFO not-empty.
- Sits between the transmit FIFO read side and the FT245 data/control pins.

Parameters:
- data_width, 8, FIFO word and FT245 bus width.
- setup_cycles, 1, cycles data is driven before WR rises (min 1).
- pulse_cycles, 2, WR high width in cycles (min 1).
- hold_cycles, 1, cycles data is held after WR falls (min 1).
- recover_cycles, 3, cycles after hold before TXE# is sampled again (min 3, covers the 2-flop synchroniser plus 1).
- count_width, 16, width of transmitted-byte counter.

Ports:
- clk  input  1  block clock, also the FIFO read clock.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag (read domain).
- fifo_rd_en  output  1  FIFO read enable, one-cycle pulse per byte.
- fifo_rd_data  input  data_width  FIFO registered read data; valid the cycle after the rd_en cycle.
- ft_txe_n  input  1  FT245 TXE#, asynchronous, low = chip can accept a byte.
- ft_wr  output  1  FT245 WR strobe, active high; the chip latches on the falling edge.
- ft_data  output  data_width  byte driven to FT245 bus.
- ft_data_oe  output  1  bus output enable for ft_data tristate.
- busy  output  1  high whenever state is not IDLE.
- byte_count  output  count_width  bytes written, wraps modulo 2^count_width.

Behaviour:
- Reset values (at the reset edge, all registered): state=IDLE, fifo_rd_en=0, ft_wr=0, ft_data=0, ft_data_oe=0, busy=0, byte_count=0, synchroniser flops=1 (not ready).
- ft_txe_n passes through a 2-flop synchroniser giving txe_sync_n. It is used only in IDLE.
- All outputs are decoded from registered state and counters. There is no combinational path from inputs to outputs.
- IDLE: if fifo_empty==0 and txe_sync_n==0, go to POP; otherwise stay.
- POP: fifo_rd_en=1 for exactly this cycle. Unconditionally go to LATCH.
  - The FIFO cannot become empty between IDLE and POP because this block is its only reader.
- LATCH: fifo_rd_data is now valid. At the end of this cycle it is registered into ft_data and ft_data_oe goes to 1. Go to SETUP.
- SETUP: ft_wr=0, data driven. Stay for setup_cycles cycles, then go to STROBE.
- STROBE: ft_wr=1 for pulse_cycles cycles. byte_count increments by 1 on the final STROBE cycle edge. Then go to HOLD.
- HOLD: ft_wr=0, ft_data held, oe=1 for hold_cycles cycles. Then go to RECOVER.
- RECOVER: ft_data_oe=0 and ft_data keeps its last value. Stay for recover_cycles cycles, then go to IDLE.
  - TXE# is ignored here so that a stale synchronised low is never used to start the next byte.
- Per-cycle counter: a single down-counter is loaded on each state entry and is wide enough for the largest parameter.
- Byte period with defaults: 1 POP + 1 LATCH + 1 SETUP + 2 STROBE + 1 HOLD + 3 RECOVER + 1 IDLE = 10 cycles.
- Once POP is entered the byte always completes the full sequence. A rise of TXE# or fifo_empty mid-sequence has no effect.
- Reset mid-sequence: the next edge forces the reset values. ft_wr falls at that edge, and the in-flight byte is dropped (already popped).
- fifo_empty is forced low by the FIFO while it is in reset. This is harmless because this block is held in IDLE by the same reset.
- byte_count wraps from 2^count_width-1 to 0 with no flag.

Test Plan:
- FIFO holds 0xA5, TXE# low → one fifo_rd_en pulse.
  - ft_data=0xA5 with oe from SETUP through HOLD; ft_wr high exactly 2 cycles starting 3 cycles after POP.
  - byte_count=1; back in IDLE 10 cycles after leaving IDLE.
- FIFO holds 0x01,0x02,0x03, TXE# held low → three WR pulses carrying 0x01,0x02,0x03 in order, 10 cycles apart; byte_count=3; fifo_rd_en pulses never overlap.
- TXE# high, FIFO non-empty for 50 cycles → no fifo_rd_en, ft_wr=0, busy=0. Drop TXE# → POP occurs 3 cycles later (2 sync + 1).
- TXE# rises during STROBE → byte still completes with correct data and hold; no new POP until TXE# is low again after RECOVER.
- reset asserted for one cycle in the second STROBE cycle → next edge: ft_wr=0, oe=0, state IDLE, byte_count=0; a following byte (0x5A) transfers normally.
- count_width=4, 17 bytes sent → byte_count reads 0 after 16th byte, 1 after 17th.
